// File: rtl/bram1be_server_if.sv
// Client/BRAM-side signal bundle for bram1be_server.
// The server takes the slave view: it accepts requests, returns responses
// and drives the BRAM pins. The client/memory side takes the master view.
interface bram1be_server_if #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int WE_WIDTH   = 1
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [WE_WIDTH-1:0]   req_be;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;

  logic                  bram_en;
  logic [WE_WIDTH-1:0]   bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_di;
  logic [DATA_WIDTH-1:0] bram_do;

  modport slave (
    input  req_valid, req_write, req_be, req_addr, req_data,
    input  resp_ready,
    input  bram_do,
    output req_ready,
    output resp_valid, resp_data,
    output bram_en, bram_we, bram_addr, bram_di
  );

  modport master (
    output req_valid, req_write, req_be, req_addr, req_data,
    output resp_ready,
    output bram_do,
    input  req_ready,
    input  resp_valid, resp_data,
    input  bram_en, bram_we, bram_addr, bram_di
  );
endinterface

// File: rtl/bram1be_server.sv
// Valid/ready front end for a single-port byte-enable BRAM.
// Requests go straight to the BRAM pins in the accept cycle. Read results
// come back after the BRAM latency and land in a small FIFO. A credit
// counter (reads accepted but not yet popped) holds back new reads so the
// FIFO can never overflow and no read result is ever dropped.
module bram1be_server #(
  parameter int PIPELINED  = 0,
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int CHUNKSIZE  = 1,
  parameter int WE_WIDTH   = 1,
  parameter int RESP_DEPTH = 4
) (
  input logic             CLK,
  input logic             RST,
  bram1be_server_if.slave bus
);

  localparam int L  = 1 + PIPELINED;
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = PW + 1;

  logic                  fire;
  logic                  rd_fire;
  logic                  push;
  logic                  pop;
  logic                  resp_valid;

  logic [L-1:0]          inflight_q, inflight_d;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         outst_q, outst_d;
  logic [DATA_WIDTH-1:0] fifo_q [RESP_DEPTH];

  // Writes are always accepted; reads need a free credit. The credit count
  // is registered, so a pop only frees its slot on the following cycle and
  // req_ready never depends on resp_ready.
  assign bus.req_ready = bus.req_write | (outst_q < CW'(RESP_DEPTH));
  assign fire          = bus.req_valid & bus.req_ready & ~RST;
  assign rd_fire       = fire & ~bus.req_write;

  assign bus.bram_en   = fire;
  assign bus.bram_we   = (fire & bus.req_write) ? bus.req_be : '0;
  assign bus.bram_addr = bus.req_addr;
  assign bus.bram_di   = bus.req_data;

  // The oldest in-flight stage lines up with valid data on bram_do.
  assign push           = inflight_q[L-1];
  assign resp_valid     = (count_q != '0);
  assign pop            = resp_valid & bus.resp_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_data  = fifo_q[rd_ptr_q];

  // Next-state for the read-latency shift register and the two counters.
  always_comb begin
    inflight_d = (inflight_q << 1) | L'(rd_fire);
    count_d    = count_q + CW'(push) - CW'(pop);
    outst_d    = outst_q + CW'(rd_fire) - CW'(pop);
  end

  // Control state: in-flight tracking, FIFO pointers, occupancy and credits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Response storage; contents need no reset since occupancy guards them.
  always_ff @(posedge CLK) begin
    if (push) fifo_q[wr_ptr_q] <= bus.bram_do;
  end

`ifndef SYNTHESIS
  if (DATA_WIDTH != WE_WIDTH * CHUNKSIZE) begin : g_bad_lanes
    $error("bram1be_server: DATA_WIDTH must equal WE_WIDTH*CHUNKSIZE");
  end
  if (RESP_DEPTH < 2 || (RESP_DEPTH & (RESP_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bram1be_server: RESP_DEPTH must be a power of two >= 2");
  end

  // Credits make FIFO overflow and counter overrun impossible.
  always @(posedge CLK) begin
    if (!RST) begin
      assert (!(push && count_q == CW'(RESP_DEPTH)));
      assert (outst_q <= CW'(RESP_DEPTH));
      assert (count_q <= outst_q);
    end
  end
`endif

endmodule

// File: doc/bram1be_server.md
Name: bram1be_server

Overview:
- Request/response front end that sits directly upstream of the single-ported byte-enable BRAM (BRAM1BE).
- Accepts valid/ready memory requests, drives the BRAM EN/WE/ADDR/DI pins, and tracks the BRAM read latency (1 or 2 cycles, per PIPELINED).
- Captures read data into a small response FIFO, using credit-based flow control so no read result is ever dropped.
- Lets any client with backpressure use the BRAM without knowing its pipeline depth.

Parameters:
- PIPELINED, 0, must match the attached BRAM; BRAM read latency L = 1 + PIPELINED.
- ADDR_WIDTH, 1, BRAM address width.
- DATA_WIDTH, 1, BRAM data width.
- CHUNKSIZE, 1, bits per byte-enable lane.
- WE_WIDTH, 1, number of byte-enable lanes; DATA_WIDTH = WE_WIDTH*CHUNKSIZE.
- RESP_DEPTH, 4, response FIFO entries and maximum outstanding reads; power of two, ≥ 2.

Ports:
- CLK  in  1  sole clock.
- RST  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid & req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_be  in  WE_WIDTH  byte enables for writes; ignored on reads.
- req_addr  in  ADDR_WIDTH  word address.
- req_data  in  DATA_WIDTH  write data.
- resp_valid  out  1  read data available.
- resp_ready  in  1  consumer takes the response.
- resp_data  out  DATA_WIDTH  read data, in request order.
- bram_en  out  1  to BRAM EN.
- bram_we  out  WE_WIDTH  to BRAM WE.
- bram_addr  out  ADDR_WIDTH  to BRAM ADDR.
- bram_di  out  DATA_WIDTH  to BRAM DI.
- bram_do  in  DATA_WIDTH  from BRAM DO.

Behaviour:
- Clock and reset: CLK only; RST is synchronous, active-high.
- Reset state: resp_valid=0; outstanding=0; FIFO empty; in-flight pipeline cleared; bram_en=0 while RST is high.
- Handshake:
  - fire = req_valid & req_ready & !RST.
  - bram_en = fire (combinational, same cycle).
  - bram_we = (fire & req_write) ? req_be : 0.
  - bram_addr = req_addr; bram_di = req_data.
- Writes:
  - Always ready: req_ready = 1 when req_write=1.
  - Writes generate no response.
  - A write with req_be=0 still pulses bram_en, changes no memory, and gives no response.
- Reads:
  - req_ready = (outstanding < RESP_DEPTH) when req_write=0.
  - outstanding counts reads accepted but not yet popped (in-flight plus FIFO occupancy). Width is clog2(RESP_DEPTH)+1.
  - req_ready must not depend combinationally on resp_ready. A pop frees its credit on the next cycle.
- In-flight tracking:
  - An L-stage valid shift register; stage 0 is loaded with (fire & !req_write).
  - When stage L-1 is set, bram_do is pushed into the FIFO at the end of that cycle. Capture happens exactly L cycles after the accept edge.
- Latency: a read accepted in cycle T pushes at the end of T+L. resp_valid rises in cycle T+L+1, i.e. L+1 cycles after accept: 2 for PIPELINED=0, 3 for PIPELINED=1.
- Throughput: one request per cycle. Reads run back-to-back at full rate while credits remain.
- FIFO:
  - resp_data is driven from the head entry; resp_valid = !empty.
  - Pop occurs on resp_valid & resp_ready.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - Overflow is impossible by credit construction. Add a simulation-only assertion that no push happens when the FIFO is full.
- Outstanding counter:
  - +1 on read accept; -1 on pop; unchanged when both occur in the same cycle.
  - Saturation is impossible; assert 0 ≤ outstanding ≤ RESP_DEPTH.
- Ordering:
  - Responses are returned strictly in read-accept order.
  - Read-after-write to the same address in consecutive cycles returns the new data, via BRAM write-then-read ordering across cycles.
- Reset mid-operation:
  - In-flight reads and queued responses are discarded.
  - resp_valid is 0 from the cycle after RST is sampled high.
  - All RESP_DEPTH credits are available once RST is deasserted.
- Pointer wrap: FIFO read and write pointers wrap modulo RESP_DEPTH with no bubble.

Test Plan:
All scenarios use ADDR_WIDTH=8, DATA_WIDTH=32, CHUNKSIZE=8, WE_WIDTH=4, RESP_DEPTH=4, except where a scenario overrides a parameter.
- Basic write/read: write 0xDEADBEEF, be=4'hF, to addr 5; then read addr 5 -> resp_data=0xDEADBEEF. resp_valid rises exactly 2 cycles after the read accept with PIPELINED=0, and exactly 3 with PIPELINED=1.
- Byte enables: over the scenario above, write 0x11223344 with be=4'b0101 to addr 5, then read -> 0xDE22BE44. A write with be=0 leaves the word unchanged.
- Backpressure: hold resp_ready=0 and offer reads of addrs 0..5 back-to-back -> exactly 4 accepted, then req_ready=0 for reads. A write offered meanwhile is accepted. Release resp_ready -> 4 responses in order for addrs 0,1,2,3; reads 4 and 5 are accepted afterwards.
- Credit timing: with outstanding=4, pop a response and offer a read in the same cycle -> read not accepted that cycle, accepted the next cycle.
- Streaming wrap: resp_ready=1 with 20 consecutive reads of a pre-filled ramp (mem[i]=i*0x01010101) -> 20 in-order correct responses, no stall after the first fill, pointers wrapped ≥ 4 times.
- Reset mid-flight: 2 reads in flight plus 1 queued, assert RST for 1 cycle -> resp_valid=0 thereafter with no stale response. After reset, 4 reads are accepted back-to-back.
